// File: rtl/seq_det_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : seq_det_pkg
// Brief    : Shared constants and elaboration-time transition helpers for the
//            parametrised serial sequence detector.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int   MAX_LEN    = 16;
  localparam logic MODE_MEALY = 1'b1;
  localparam logic MODE_MOORE = 1'b0;

  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic logic bit_at(input logic [MAX_LEN:0] v, input int idx);
    logic [MAX_LEN:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  // Bit i of the pattern counted from the MSB, i.e. the i-th bit on the line.
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pattern, input int len,
                                   input int i);
    return bit_at({1'b0, pattern}, len - 1 - i);
  endfunction

  // Longest proper prefix of the full pattern that is also a suffix of it.
  function automatic int border(input logic [MAX_LEN-1:0] pattern, input int len);
    int   res;
    logic ok;
    res = 0;
    for (int k = MAX_LEN - 1; k >= 1; k--) begin
      if (res == 0 && k < len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < k && pat_bit(pattern, len, len - k + j) != pat_bit(pattern, len, j))
            ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // Rebuilds the received history (matched prefix plus new bit) and searches
  // for the longest suffix that is a pattern prefix.
  function automatic int seq_next(input logic [MAX_LEN-1:0] pattern, input int len,
                                  input int state, input logic bit_in,
                                  input logic overlap);
    logic [MAX_LEN:0] hist;
    int               base;
    int               n;
    int               res;
    logic             ok;
    base = state;
    if (state >= len) base = overlap ? border(pattern, len) : 0;
    hist = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      if (j < base) hist = hist | ((MAX_LEN + 1)'(pat_bit(pattern, len, j)) << j);
    end
    hist = hist | ((MAX_LEN + 1)'(bit_in) << base);
    n    = base + 1;
    res  = 0;
    for (int k = MAX_LEN; k >= 1; k--) begin
      if (res == 0 && k <= n) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < k && bit_at(hist, n - k + j) != pat_bit(pattern, len, j)) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : seq_match_counter
// Brief    : Saturating match counter; clear wins over a same-cycle increment.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module seq_match_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : seq_detector_param
// Brief    : Parametrised serial pattern detector with overlap/Mealy options,
//            input qualifier and saturating match counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 MEALY   = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = state_w(PAT_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic [SW-1:0]    ps,
  output logic [SW-1:0]    ns
);

  logic [SW-1:0] r_ps;
  logic [SW-1:0] w_ns;
  logic          w_match;
  logic [SW-1:0] w_or [PAT_LEN+2];

  // One-hot select over the elaboration-time table; unreachable codes give 0.
  assign w_or[0] = '0;
  for (genvar s = 0; s <= PAT_LEN; s++) begin : g_tbl
    localparam int c_nxt0 = seq_next(MAX_LEN'(PATTERN), PAT_LEN, s, 1'b0, OVERLAP);
    localparam int c_nxt1 = seq_next(MAX_LEN'(PATTERN), PAT_LEN, s, 1'b1, OVERLAP);
    assign w_or[s+1] = w_or[s] |
                       ((r_ps == SW'(s)) ? (x ? SW'(c_nxt1) : SW'(c_nxt0)) : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ps <= '0;
    end else begin
      r_ps <= w_ns;
    end
  end

  always_comb begin
    w_ns    = r_ps;
    w_match = 1'b0;
    if (en) begin
      w_ns    = w_or[PAT_LEN+1];
      w_match = (w_ns == SW'(PAT_LEN));
    end
  end

  if (MEALY == MODE_MEALY) begin : g_mealy
    assign y = w_match;
  end else begin : g_moore
    assign y = (r_ps == SW'(PAT_LEN));
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_match),
    .clr   (clr_cnt),
    .count (match_count)
  );

  assign ps = r_ps;
  assign ns = w_ns;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_seq_detector_param
// Brief    : Directed scoreboard bench over four detector configurations.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, x, clr_cnt;
  logic       y_a, y_b, y_c, y_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;
  logic [2:0] ps_a, ns_a, ps_b, ns_b, ps_c, ns_c;
  logic [1:0] ps_d, ns_d;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8))
    u_a (.clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
         .y(y_a), .match_count(cnt_a), .ps(ps_a), .ns(ns_a));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b1), .CNT_W(8))
    u_b (.clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
         .y(y_b), .match_count(cnt_b), .ps(ps_b), .ns(ns_b));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(8))
    u_c (.clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
         .y(y_c), .match_count(cnt_c), .ps(ps_c), .ns(ns_c));
  seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(2))
    u_d (.clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
         .y(y_d), .match_count(cnt_d), .ps(ps_d), .ns(ns_d));

  localparam int A_Y = 0, A_PS = 1, A_CNT = 2, B_Y = 3, B_PS = 4, B_CNT = 5;
  localparam int C_Y = 6, C_PS = 7, D_Y = 8, D_CNT = 9;
  string names [10] = '{"a_y", "a_ps", "a_cnt", "b_y", "b_ps", "b_cnt",
                        "c_y", "c_ps", "d_y", "d_cnt"};

  typedef struct {
    int sel;
    int val;
    bit late;
  } exp_t;
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int t1_bit [7] = '{1, 0, 1, 1, 0, 1, 1};
  int t1_aps [7] = '{1, 2, 3, 4, 2, 3, 4};
  int t1_ay  [7] = '{0, 0, 0, 1, 0, 0, 1};
  int t1_bps [7] = '{1, 2, 3, 4, 0, 1, 1};
  int t1_by  [7] = '{0, 0, 0, 1, 0, 0, 0};
  int t1_cy  [7] = '{0, 0, 0, 1, 0, 0, 1};

  int t4_bit [8] = '{1, 0, 1, 1, 1, 1, 1, 1};
  int t4_en  [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
  int t4_aps [8] = '{1, 2, 2, 2, 2, 3, 4, 4};
  int t4_ay  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int t4_cy  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      A_Y:     return 32'(y_a);
      A_PS:    return 32'(ps_a);
      A_CNT:   return 32'(cnt_a);
      B_Y:     return 32'(y_b);
      B_PS:    return 32'(ps_b);
      B_CNT:   return 32'(cnt_b);
      C_Y:     return 32'(y_c);
      C_PS:    return 32'(ps_c);
      D_Y:     return 32'(y_d);
      D_CNT:   return 32'(cnt_d);
      default: return 'x;
    endcase
  endfunction

  // Early entries are checked mid-cycle (combinational), late ones after the edge.
  function automatic void push(input int sel, input int val, input bit late);
    exp_t t;
    t.sel  = sel;
    t.val  = val;
    t.late = late;
    sb.push_back(t);
  endfunction

  task automatic drain(input bit phase);
    exp_t        t;
    logic [31:0] obs;
    while (sb.size() > 0 && sb[0].late == phase) begin
      t   = sb.pop_front();
      obs = observe(t.sel);
      n_checks++;
      assert (obs === 32'(t.val)) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", names[t.sel], obs, t.val);
      end
    end
  endtask

  task automatic cycle(input logic b, input logic e, input logic c);
    x       = b;
    en      = e;
    clr_cnt = c;
    @(negedge clk);
    drain(1'b0);
    @(posedge clk);
    #1;
    drain(1'b1);
  endtask

  task automatic do_reset();
    en      = 1'b0;
    x       = 1'b0;
    clr_cnt = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; x = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(A_PS, 0, 1'b1); push(A_CNT, 0, 1'b1); push(A_Y, 0, 1'b1);
    push(C_PS, 0, 1'b1); push(C_Y, 0, 1'b1); push(D_CNT, 0, 1'b1);
    drain(1'b1);
    rst = 1'b1;

    // Stream 1011011 on overlap/non-overlap Mealy and overlap Moore.
    for (int i = 0; i < 7; i++) begin
      push(A_Y, t1_ay[i], 1'b0);
      push(B_Y, t1_by[i], 1'b0);
      push(C_Y, (i == 0) ? 0 : t1_cy[i-1], 1'b0);
      push(A_PS, t1_aps[i], 1'b1);
      push(B_PS, t1_bps[i], 1'b1);
      push(C_PS, t1_aps[i], 1'b1);
      push(C_Y, t1_cy[i], 1'b1);
      if (i == 3) push(A_CNT, 1, 1'b1);
      cycle(1'(t1_bit[i]), 1'b1, 1'b0);
    end
    push(A_CNT, 2, 1'b1); push(B_CNT, 1, 1'b1);
    drain(1'b1);

    // Enable gap between bits 2 and 3; x=1 during the gap must be ignored.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(A_Y, t4_ay[i], 1'b0);
      push(C_Y, (i == 0) ? 0 : t4_cy[i-1], 1'b0);
      push(A_PS, t4_aps[i], 1'b1);
      push(C_PS, t4_aps[i], 1'b1);
      push(C_Y, t4_cy[i], 1'b1);
      cycle(1'(t4_bit[i]), 1'(t4_en[i]), 1'b0);
    end
    push(A_CNT, 1, 1'b1);
    drain(1'b1);

    // Pattern 11 on 111111 with a 2-bit counter, then clear vs. match.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(D_Y, (i == 0) ? 0 : 1, 1'b0);
      push(D_CNT, (i > 3) ? 3 : i, 1'b1);
      cycle(1'b1, 1'b1, 1'b0);
    end
    push(D_Y, 1, 1'b0);
    push(D_CNT, 0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    push(D_CNT, 1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle after 101.
    do_reset();
    push(A_PS, 1, 1'b1); cycle(1'b1, 1'b1, 1'b0);
    push(A_PS, 2, 1'b1); cycle(1'b0, 1'b1, 1'b0);
    push(A_PS, 3, 1'b1); cycle(1'b1, 1'b1, 1'b0);
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    push(A_PS, 0, 1'b1); push(B_PS, 0, 1'b1); push(C_PS, 0, 1'b1);
    drain(1'b1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(A_PS, 0, 1'b1);
    drain(1'b1);
    push(A_Y, 0, 1'b0);
    push(A_PS, 1, 1'b1);
    push(A_CNT, 0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    push(A_Y, 0, 1'b0);
    push(A_PS, 2, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
